logsys_spi_shifter: RTL and testbench

SPI byte-shift engine that sits directly behind the AXI SPI register interface and drives the LOGSYS board SPI bus: flash, LCD and SD card share one clock/MOSI/MISO, each with its own active-low chip select. The register interface hands over one byte plus a chip-select choice. This block runs a mode-0, MSB-first transfer at a programmable SCK rate, returns the received byte, and optionally raises an interrupt.

---
 rtl/logsys_spi_shifter.sv | 146 ++++++++++++++
 tb/tb_logsys_spi_shifter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/logsys_spi_shifter.sv
// Mode-0, MSB-first SPI byte engine for the LOGSYS flash/LCD/SD bus.
// Optional completion interrupt enabled by defining LOGSYS_SPI_IRQ_EN.
//
// state  | meaning
// IDLE   | ready for a byte; held CS may be released
// LOW    | SCK low, MOSI presents the current bit
// HIGH   | SCK high, sampled MISO shifted in at the end
// HOLD   | SCK low tail before CS release / next byte
module logsys_spi_shifter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic [1:0] cs_sel,
  input  logic       cs_keep,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       cs_release,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       irq,
  input  logic       irq_ack,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       flash_csn,
  output logic       lcd_csn,
  output logic       sdcard_csn
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] shift_lo;
  logic       miso_s;
  logic       keep_q;
  logic       accept;
  logic       phase_end;

  assign accept    = tx_valid && tx_ready;
  assign phase_end = (div_cnt == DIV_LAST);

  function automatic logic [2:0] csn_decode(input logic [1:0] sel);
    case (sel)
      2'b01:   csn_decode = 3'b011;
      2'b10:   csn_decode = 3'b101;
      2'b11:   csn_decode = 3'b110;
      default: csn_decode = 3'b111;
    endcase
  endfunction

  // spi_mosi doubles as the MSB of the shift register so the line is always registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= 8'd0;
      bit_cnt  <= 3'd0;
      shift_lo <= 7'd0;
      miso_s   <= 1'b0;
      keep_q   <= 1'b0;
      tx_ready <= 1'b1;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      {flash_csn, lcd_csn, sdcard_csn} <= 3'b111;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            {spi_mosi, shift_lo} <= tx_data;
            keep_q   <= cs_keep;
            bit_cnt  <= 3'd7;
            div_cnt  <= 8'd0;
            tx_ready <= 1'b0;
            {flash_csn, lcd_csn, sdcard_csn} <= csn_decode(cs_sel);
            state    <= S_LOW;
          end else if (cs_release) begin
            {flash_csn, lcd_csn, sdcard_csn} <= 3'b111;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            miso_s  <= spi_miso;
            div_cnt <= 8'd0;
            spi_clk <= 1'b1;
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            div_cnt <= 8'd0;
            spi_clk <= 1'b0;
            if (bit_cnt != 3'd0) begin
              {spi_mosi, shift_lo} <= {shift_lo, miso_s};
              bit_cnt <= bit_cnt - 3'd1;
              state   <= S_LOW;
            end else begin
              rx_data  <= {shift_lo, miso_s};
              rx_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (phase_end) begin
            div_cnt  <= 8'd0;
            tx_ready <= 1'b1;
            if (!keep_q) {flash_csn, lcd_csn, sdcard_csn} <= 3'b111;
            state    <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LOGSYS_SPI_IRQ_EN
  logic done_set;
  assign done_set = (state == S_HIGH) && phase_end && (bit_cnt == 3'd0);

  // An ack overlapping the completion edge or the rx_valid cycle cannot drop a fresh interrupt.
  always_ff @(posedge clk) begin
    if (rst)                      irq <= 1'b0;
    else if (done_set || rx_valid) irq <= 1'b1;
    else if (irq_ack)             irq <= 1'b0;
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_logsys_spi_shifter.sv
// Randomized self-checking bench for logsys_spi_shifter with a bit-level SPI slave
// and expected timing derived from the byte-transfer rules.
module tb_logsys_spi_shifter;
  localparam int CD = 4;
`ifdef LOGSYS_SPI_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] cs_sel = 2'b00;
  logic       cs_keep = 1'b0;
  logic       tx_valid = 1'b0;
  logic       cs_release = 1'b0;
  logic       irq_ack = 1'b0;
  logic       spi_miso = 1'b0;
  logic       tx_ready, rx_valid, irq, spi_clk, spi_mosi;
  logic       flash_csn, lcd_csn, sdcard_csn;
  logic [7:0] rx_data;
  logic [2:0] csn_v;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc = 0;

  logsys_spi_shifter #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .cs_sel(cs_sel), .cs_keep(cs_keep),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .cs_release(cs_release),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq), .irq_ack(irq_ack),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .flash_csn(flash_csn), .lcd_csn(lcd_csn), .sdcard_csn(sdcard_csn)
  );

  assign csn_v = {flash_csn, lcd_csn, sdcard_csn};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] sel_csn(input logic [1:0] sel);
    case (sel)
      2'b01:   return 3'b011;
      2'b10:   return 3'b101;
      2'b11:   return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic clear_irq(input string tag);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk({tag, "/irq_clear"}, 32'(irq), 32'd0);
  endtask

  // One byte: accept, then watch every cycle up to 17*CD edges after the accept.
  // ack_mode: 0 none, 1 ack in the cycle before completion, 2 ack during rx_valid.
  task automatic run_byte(input string tag, input logic [7:0] data, input logic [1:0] sel,
                          input logic keep, input logic [7:0] mbyte, input int ack_mode,
                          output int unsigned e0);
    int first_rise = -1, rxv_k = -1, rxv_n = 0, rises = 0, ready_k = -1;
    int cs_bad = 0, mosi_bad = 0, falls = 0, waited = 0;
    logic [7:0] mosi_got = 8'h00, rx_at = 8'h00;
    logic [2:0] exp_cs;
    logic prev_clk, prev_mosi;
    while (!tx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "/ready_in"}, 32'(tx_ready), 32'd1);
    tx_data  = data;
    cs_sel   = sel;
    cs_keep  = keep;
    tx_valid = 1'b1;
    spi_miso = mbyte[7];
    @(negedge clk);
    tx_valid = 1'b0;
    e0 = cyc;
    chk({tag, "/busy"}, 32'(tx_ready), 32'd0);
    prev_clk  = 1'b0;
    prev_mosi = spi_mosi;
    for (int k = 0; k <= 17 * CD; k++) begin
      if (k > 0) @(negedge clk);
      if (spi_clk && !prev_clk) begin
        if (first_rise < 0) first_rise = k;
        mosi_got = {mosi_got[6:0], spi_mosi};
        rises++;
      end
      if (!spi_clk && prev_clk) begin
        falls++;
        if (falls < 8) spi_miso = mbyte[3'(7 - falls)];
      end
      if (prev_clk && spi_clk && (spi_mosi !== prev_mosi)) mosi_bad++;
      if (rx_valid) begin
        rxv_n++;
        rxv_k = k;
        rx_at = rx_data;
      end
      if (tx_ready && ready_k < 0) ready_k = k;
      exp_cs = (k < 17 * CD || keep) ? sel_csn(sel) : 3'b111;
      if (csn_v !== exp_cs) cs_bad++;
      if (k == 16 * CD) chk({tag, "/irq_set"}, 32'(irq), 32'(IRQ_ON));
      if (ack_mode == 1 && k == 16 * CD - 1) irq_ack = 1'b1;
      if (k == 16 * CD) irq_ack = (ack_mode == 2);
      if (ack_mode != 0 && k == 16 * CD + 1) begin
        irq_ack = 1'b0;
        chk({tag, "/irq_ack_race"}, 32'(irq), 32'(IRQ_ON));
      end
      prev_clk  = spi_clk;
      prev_mosi = spi_mosi;
    end
    chk({tag, "/first_rise"}, 32'(first_rise), 32'(CD));
    chk({tag, "/rises"}, 32'(rises), 32'd8);
    chk({tag, "/mosi"}, 32'(mosi_got), 32'(data));
    chk({tag, "/mosi_hi_stable"}, 32'(mosi_bad), 32'd0);
    chk({tag, "/rxv_count"}, 32'(rxv_n), 32'd1);
    chk({tag, "/rxv_cycle"}, 32'(rxv_k), 32'(16 * CD));
    chk({tag, "/rx_data"}, 32'(rx_at), 32'(mbyte));
    chk({tag, "/rx_hold"}, 32'(rx_data), 32'(mbyte));
    chk({tag, "/ready_cycle"}, 32'(ready_k), 32'(17 * CD));
    chk({tag, "/cs_cycles"}, 32'(cs_bad), 32'd0);
  endtask

  initial begin
    int unsigned e0a, e0b;
    int hi_n, rxv_n, sck_n;
    logic [7:0] d, m;
    logic [1:0] s;
    logic kp;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/tx_ready", 32'(tx_ready), 32'd1);
    chk("rst/spi_clk", 32'(spi_clk), 32'd0);
    chk("rst/spi_mosi", 32'(spi_mosi), 32'd0);
    chk("rst/csn", 32'(csn_v), 32'h7);
    chk("rst/rx_data", 32'(rx_data), 32'h00);
    chk("rst/rx_valid", 32'(rx_valid), 32'd0);
    chk("rst/irq", 32'(irq), 32'd0);

    run_byte("flash_a5", 8'hA5, 2'b01, 1'b0, 8'h3C, 0, e0a);

    hi_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (irq) hi_n++;
    end
    chk("irq_hold", 32'(hi_n), IRQ_ON ? 32'd10 : 32'd0);
    clear_irq("irq_hold");

    run_byte("b2b_1", 8'h9F, 2'b01, 1'b1, 8'($urandom), 0, e0a);
    run_byte("b2b_2", 8'h00, 2'b01, 1'b0, 8'($urandom), 0, e0b);
    chk("b2b/period", e0b - e0a, 32'(17 * CD + 1));
    clear_irq("b2b");

    run_byte("dummy", 8'hFF, 2'b00, 1'b0, 8'($urandom), 0, e0a);

    run_byte("lcd_keep", 8'($urandom), 2'b10, 1'b1, 8'($urandom), 0, e0a);
    run_byte("sd_switch", 8'($urandom), 2'b11, 1'b1, 8'($urandom), 0, e0a);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    chk("release/csn", 32'(csn_v), 32'h7);
    clear_irq("release");

    cs_release = 1'b1;
    run_byte("accept_over_release", 8'($urandom), 2'b01, 1'b1, 8'($urandom), 2, e0a);
    cs_release = 1'b0;
    clear_irq("ack_rxv");
    run_byte("ack_before_set", 8'($urandom), 2'b10, 1'b0, 8'($urandom), 1, e0a);
    clear_irq("ack_before");

    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      m  = 8'($urandom);
      s  = 2'($urandom_range(0, 3));
      kp = 1'($urandom_range(0, 1));
      run_byte($sformatf("rand%0d", i), d, s, kp, m, 0, e0a);
      clear_irq($sformatf("rand%0d", i));
    end

    run_byte("pre_rst", 8'h5A, 2'b11, 1'b0, 8'hC3, 0, e0a);
    tx_data = 8'h81; cs_sel = 2'b01; cs_keep = 1'b1; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (9 * CD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst/csn", 32'(csn_v), 32'h7);
    chk("midrst/spi_clk", 32'(spi_clk), 32'd0);
    chk("midrst/tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst/rx_data", 32'(rx_data), 32'h00);
    chk("midrst/irq", 32'(irq), 32'd0);
    rst = 1'b0;
    rxv_n = 0;
    sck_n = 0;
    for (int i = 0; i < 20 * CD; i++) begin
      @(negedge clk);
      if (rx_valid) rxv_n++;
      if (spi_clk) sck_n++;
    end
    chk("midrst/no_rxv", 32'(rxv_n), 32'd0);
    chk("midrst/no_sck", 32'(sck_n), 32'd0);
    chk("midrst/rx_data_after", 32'(rx_data), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
